// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, widths and FSM encoding for the MIPS32e pipeline control unit.
package pipe_ctrl_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned STALL_W  = 5;
  localparam int unsigned SETTLE_W = 3;
  localparam int unsigned FCNT_W   = 16;
  localparam int unsigned RUN_W    = 16;

  localparam logic [XLEN-1:0] EXC_NONE = 32'h0000_0000;
  localparam logic [XLEN-1:0] EXC_ERET = 32'h0000_000e;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  typedef enum logic {
    CtrlRun    = 1'b0,
    CtrlSettle = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Stall/flush performance counters plus a sticky stall watchdog for board debug.
module pipe_ctrl_perf
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_pc,
  input  logic              flush,
  input  logic              perf_clr_i,
  output logic [XLEN-1:0]   stall_cycles_o,
  output logic [FCNT_W-1:0] flush_count_o,
  output logic              stall_timeout_o
);

  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_inc;

  assign run_inc = run_q + RUN_W'(1);

  // Clear has priority over any same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_o  <= '0;
      flush_count_o   <= '0;
      run_q           <= '0;
      stall_timeout_o <= 1'b0;
    end else if (perf_clr_i) begin
      stall_cycles_o  <= '0;
      flush_count_o   <= '0;
      run_q           <= '0;
      stall_timeout_o <= 1'b0;
    end else begin
      stall_cycles_o <= stall_cycles_o + XLEN'(stall_pc);
      flush_count_o  <= flush_count_o + FCNT_W'(flush);
      run_q          <= stall_pc ? run_inc : '0;
      if (stall_pc && (run_inc == RUN_W'(STALL_TIMEOUT))) begin
        stall_timeout_o <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall priority encoding, exception flush/redirect with a
// post-flush settle window, and debug performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = 32'h8000_1180,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned STALL_TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_from_if,
  input  logic               stallreq_from_id,
  input  logic               stallreq_from_ex,
  input  logic               stallreq_from_mem,
  input  logic [XLEN-1:0]    excepttype_i,
  input  logic [XLEN-1:0]    cp0_epc_i,
  input  logic               perf_clr_i,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [XLEN-1:0]    new_pc,
  output logic [XLEN-1:0]    stall_cycles_o,
  output logic [FCNT_W-1:0]  flush_count_o,
  output logic               stall_timeout_o
);

  ctrl_state_e         state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                exc_take;
  logic [STALL_W-1:0]  stall_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CtrlRun;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  // Exceptions are accepted only in RUN; SETTLE masks stale reports behind a flush.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    exc_take = 1'b0;
    case (state_q)
      CtrlRun: begin
        if (excepttype_i != EXC_NONE) begin
          exc_take = 1'b1;
          state_d  = CtrlSettle;
          settle_d = SETTLE_W'(SETTLE_CYCLES);
        end
      end
      CtrlSettle: begin
        settle_d = settle_q - SETTLE_W'(1);
        if (settle_q <= SETTLE_W'(1)) begin
          state_d = CtrlRun;
        end
      end
    endcase
  end

  // A stalled stage also holds every stage upstream of it; WB is never held.
  always_comb begin
    stall_req    = {STALL_W{NoStop}};
    stall_req[3] = stallreq_from_mem ? Stop : NoStop;
    stall_req[2] = (stallreq_from_mem | stallreq_from_ex) ? Stop : NoStop;
    stall_req[1] = (stallreq_from_mem | stallreq_from_ex | stallreq_from_id) ? Stop : NoStop;
    stall_req[0] = (stallreq_from_mem | stallreq_from_ex | stallreq_from_id |
                    stallreq_from_if) ? Stop : NoStop;
  end

  assign flush  = exc_take & ~rst;
  assign stall  = (flush | rst) ? '0 : stall_req;
  assign new_pc = !flush                     ? '0 :
                  (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;

  pipe_ctrl_perf #(
    .STALL_TIMEOUT (STALL_TIMEOUT)
  ) u_perf (
    .clk             (clk),
    .rst             (rst),
    .stall_pc        (stall[0]),
    .flush           (flush),
    .perf_clr_i      (perf_clr_i),
    .stall_cycles_o  (stall_cycles_o),
    .flush_count_o   (flush_count_o),
    .stall_timeout_o (stall_timeout_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two parameterisations driven in lockstep and checked
// every cycle against a behavioural model, plus hand-computed anchor checks.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sr_if, sr_id, sr_ex, sr_mem;
  logic [31:0] exc, epc;
  logic        clr;

  logic [4:0]  stall_a, stall_b;
  logic        flush_a, flush_b;
  logic [31:0] pc_a, pc_b;
  logic [31:0] sc_a, sc_b;
  logic [15:0] fc_a, fc_b;
  logic        to_a, to_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.EXC_VECTOR(32'h8000_1180), .SETTLE_CYCLES(1), .STALL_TIMEOUT(4)) u_dut_a (
    .clk(clk), .rst(rst),
    .stallreq_from_if(sr_if), .stallreq_from_id(sr_id),
    .stallreq_from_ex(sr_ex), .stallreq_from_mem(sr_mem),
    .excepttype_i(exc), .cp0_epc_i(epc), .perf_clr_i(clr),
    .stall(stall_a), .flush(flush_a), .new_pc(pc_a),
    .stall_cycles_o(sc_a), .flush_count_o(fc_a), .stall_timeout_o(to_a)
  );

  pipe_ctrl #(.EXC_VECTOR(32'h0000_0180), .SETTLE_CYCLES(3), .STALL_TIMEOUT(9)) u_dut_b (
    .clk(clk), .rst(rst),
    .stallreq_from_if(sr_if), .stallreq_from_id(sr_id),
    .stallreq_from_ex(sr_ex), .stallreq_from_mem(sr_mem),
    .excepttype_i(exc), .cp0_epc_i(epc), .perf_clr_i(clr),
    .stall(stall_b), .flush(flush_b), .new_pc(pc_b),
    .stall_cycles_o(sc_b), .flush_count_o(fc_b), .stall_timeout_o(to_b)
  );

  // Reference model state, one slot per DUT instance.
  int          ign   [2];
  logic [31:0] m_sc  [2];
  logic [15:0] m_fc  [2];
  int          m_run [2];
  logic        m_to  [2];
  logic [4:0]  e_stall [2];
  logic        e_flush [2];
  logic [31:0] e_pc    [2];

  function automatic int settle_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int timeout_of(input int k);
    return (k == 0) ? 4 : 9;
  endfunction

  function automatic logic [31:0] vector_of(input int k);
    return (k == 0) ? 32'h8000_1180 : 32'h0000_0180;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ign[k] = 0; m_sc[k] = '0; m_fc[k] = '0; m_run[k] = 0; m_to[k] = 1'b0;
    end
  endtask

  task automatic model_outputs();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        e_flush[k] = 1'b0; e_stall[k] = 5'b0; e_pc[k] = 32'h0;
      end else begin
        e_flush[k] = (exc != 32'h0) && (ign[k] == 0);
        if (e_flush[k])  e_stall[k] = 5'b00000;
        else if (sr_mem) e_stall[k] = 5'b01111;
        else if (sr_ex)  e_stall[k] = 5'b00111;
        else if (sr_id)  e_stall[k] = 5'b00011;
        else if (sr_if)  e_stall[k] = 5'b00001;
        else             e_stall[k] = 5'b00000;
        e_pc[k] = !e_flush[k] ? 32'h0 : (exc == 32'h0000_000e) ? epc : vector_of(k);
      end
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (e_flush[k])    ign[k] = settle_of(k);
      else if (ign[k] > 0) ign[k] = ign[k] - 1;
      if (clr) begin
        m_sc[k] = '0; m_fc[k] = '0; m_run[k] = 0; m_to[k] = 1'b0;
      end else begin
        m_sc[k]  = m_sc[k] + 32'(e_stall[k][0]);
        m_fc[k]  = m_fc[k] + 16'(e_flush[k]);
        m_run[k] = e_stall[k][0] ? (m_run[k] + 1) % 65536 : 0;
        if (e_stall[k][0] && m_run[k] == timeout_of(k)) m_to[k] = 1'b1;
      end
    end
  endtask

  // Apply one cycle of inputs mid-period and compare every output against the model.
  task automatic drive(input logic r, input logic fi, input logic fd, input logic fe,
                       input logic fm, input logic [31:0] ex, input logic [31:0] ep,
                       input logic c);
    @(negedge clk);
    rst = r; sr_if = fi; sr_id = fd; sr_ex = fe; sr_mem = fm;
    exc = ex; epc = ep; clr = c;
    #1;
    if (r) model_reset();
    model_outputs();
    chk("a.stall",  32'(stall_a), 32'(e_stall[0]));
    chk("a.flush",  32'(flush_a), 32'(e_flush[0]));
    chk("a.new_pc", pc_a,         e_pc[0]);
    chk("a.stall_cycles", sc_a,   m_sc[0]);
    chk("a.flush_count", 32'(fc_a), 32'(m_fc[0]));
    chk("a.timeout", 32'(to_a),   32'(m_to[0]));
    chk("b.stall",  32'(stall_b), 32'(e_stall[1]));
    chk("b.flush",  32'(flush_b), 32'(e_flush[1]));
    chk("b.new_pc", pc_b,         e_pc[1]);
    chk("b.stall_cycles", sc_b,   m_sc[1]);
    chk("b.flush_count", 32'(fc_b), 32'(m_fc[1]));
    chk("b.timeout", 32'(to_b),   32'(m_to[1]));
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst) model_update();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] rex;
    logic        heavy;
    int          rsel;
    rst = 1'b1; sr_if = 0; sr_id = 0; sr_ex = 0; sr_mem = 0;
    exc = '0; epc = '0; clr = 0;
    model_reset();

    drive(1, 0, 0, 0, 1, 32'h8, 32'h0, 0);
    chk("lit.reset_stall", 32'(stall_a), 32'h0);
    chk("lit.reset_flush", 32'(flush_a), 32'h0);
    chk("lit.reset_pc", pc_a, 32'h0);
    advance();

    drive(0, 0, 1, 1, 0, 32'h0, 32'h0, 0);
    chk("lit.prio_id_ex", 32'(stall_a), 32'h07);
    advance();
    drive(0, 1, 0, 0, 0, 32'h0, 32'h0, 0);
    chk("lit.prio_if", 32'(stall_a), 32'h01);
    chk("lit.sc_after1", sc_a, 32'd1);
    advance();

    drive(0, 0, 0, 0, 1, 32'h8, 32'h0, 0);
    chk("lit.exc_flush", 32'(flush_a), 32'h1);
    chk("lit.exc_stall", 32'(stall_a), 32'h0);
    chk("lit.exc_pc", pc_a, 32'h8000_1180);
    chk("lit.exc_pc_b", pc_b, 32'h0000_0180);
    advance();
    drive(0, 0, 0, 0, 0, 32'he, 32'h8000_0040, 0);
    chk("lit.fc_one", 32'(fc_a), 32'd1);
    chk("lit.settle_noflush", 32'(flush_a), 32'h0);
    advance();
    drive(0, 0, 0, 0, 0, 32'he, 32'h8000_0040, 0);
    chk("lit.eret_flush", 32'(flush_a), 32'h1);
    chk("lit.eret_pc", pc_a, 32'h8000_0040);
    chk("lit.b_still_settling", 32'(flush_b), 32'h0);
    advance();
    drive(0, 0, 0, 0, 0, 32'he, 32'h8000_0040, 0);
    chk("lit.eret_settle", 32'(flush_a), 32'h0);
    advance();

    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 32'h0, 32'h0, 0);
      chk("lit.wd_not_yet", 32'(to_a), 32'h0);
      advance();
    end
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    chk("lit.wd_set", 32'(to_a), 32'h1);
    advance();
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
    chk("lit.wd_sticky", 32'(to_a), 32'h1);
    advance();
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    chk("lit.wd_cleared", 32'(to_a), 32'h0);
    chk("lit.sc_cleared", sc_a, 32'h0);
    advance();

    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, 0, 0, 32'h0, 32'h0, 0);
      advance();
    end
    drive(0, 1, 0, 0, 0, 32'h0, 32'h0, 1);
    chk("lit.sc_ten", sc_a, 32'd10);
    advance();
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    chk("lit.sc_clr_wins", sc_a, 32'd0);
    advance();

    drive(0, 0, 0, 0, 0, 32'h8, 32'h0, 0);
    chk("lit.pre_rst_flush", 32'(flush_a), 32'h1);
    advance();
    drive(1, 0, 0, 0, 1, 32'h8, 32'h0, 0);
    chk("lit.rst_settle_stall", 32'(stall_a), 32'h0);
    chk("lit.rst_settle_fc", 32'(fc_a), 32'h0);
    advance();
    drive(0, 0, 0, 0, 0, 32'h8, 32'h0, 0);
    chk("lit.post_rst_flush", 32'(flush_a), 32'h1);
    chk("lit.post_rst_flush_b", 32'(flush_b), 32'h1);
    advance();

    for (int i = 0; i < 4000; i++) begin
      heavy = ((i / 150) % 2) == 1;
      rsel = int'($urandom_range(0, heavy ? 31 : 7));
      case (rsel)
        5:       rex = 32'h8;
        6:       rex = 32'he;
        7:       rex = $urandom;
        default: rex = 32'h0;
      endcase
      drive(($urandom_range(0, 499) == 0),
            heavy ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 5) == 0),
            rex, $urandom, ($urandom_range(0, 99) == 0));
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
